// File: rtl/sram_pkg.sv
// Shared types and sizes for the MEM-stage SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_tristate.sv
// Pin-side SRAM data bus: registered drive enable and output data, raw input sample.
module sram_tristate
  import sram_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drive_d,
  input  logic [SRAM_DATA_W-1:0] data_d,
  output logic [SRAM_DATA_W-1:0] sample,
  inout  wire  [SRAM_DATA_W-1:0] sram_data
);

  logic                   drive;
  logic [SRAM_DATA_W-1:0] data_q;

  // Reset releases the bus immediately, even in the middle of a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive  <= 1'b0;
      data_q <= '0;
    end else begin
      drive  <= drive_d;
      data_q <= data_d;
    end
  end

  assign sram_data = drive ? data_q : {SRAM_DATA_W{1'bz}};
  assign sample    = sram_data;

endmodule

// File: rtl/sram_ctrl.sv
// Splits each 32-bit MEM-stage access into two 16-bit asynchronous SRAM phases,
// stalling the pipeline until the word is complete.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            aluResult,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic                   SRAM_NOT_READY,
  output logic [SRAM_ADDR_W-1:0] SRAMaddress,
  output logic                   SRAMWEn,
  inout  wire  [SRAM_DATA_W-1:0] SRAMdata
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t                 state, state_n;
  logic [3:0]             cnt, cnt_n;
  logic                   op_wr, op_wr_n;
  logic [16:0]            word, word_n;
  logic [31:0]            wdata_q, wdata_n;
  logic [31:0]            off;
  logic                   last;
  logic [SRAM_ADDR_W-1:0] addr_n;
  logic                   wen_n;
  logic                   drive_n;
  logic [SRAM_DATA_W-1:0] dout_n;
  logic [SRAM_DATA_W-1:0] sample;
  logic                   unused_off_bits;

  assign off             = aluResult - BASE_ADDR;
  assign unused_off_bits = ^{off[31:19], off[1:0]};
  assign last            = (cnt == LAST);
  assign SRAM_NOT_READY  = (read | write) && (state != DONE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_wr_n = op_wr;
    word_n  = word;
    wdata_n = wdata_q;
    case (state)
      IDLE: begin
        if (read | write) begin
          state_n = LOW;
          cnt_n   = 4'd0;
          op_wr_n = write;
          word_n  = off[18:2];
          wdata_n = writedata;
        end
      end
      LOW: begin
        if (last) begin
          state_n = HIGH;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_n = DONE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pin values are derived from the next state so they can be registered glitch-free.
  always_comb begin
    addr_n  = SRAMaddress;
    wen_n   = 1'b1;
    drive_n = 1'b0;
    dout_n  = '0;
    if (state_n == LOW || state_n == HIGH) begin
      addr_n  = {word_n, state_n == HIGH};
      drive_n = op_wr_n;
      dout_n  = (state_n == HIGH) ? wdata_n[31:16] : wdata_n[15:0];
      wen_n   = ~op_wr_n | ((WAIT_CYCLES > 1) && (cnt_n == LAST));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      op_wr       <= 1'b0;
      word        <= '0;
      wdata_q     <= '0;
      SRAMaddress <= '0;
      SRAMWEn     <= 1'b1;
      readdata    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op_wr       <= op_wr_n;
      word        <= word_n;
      wdata_q     <= wdata_n;
      SRAMaddress <= addr_n;
      SRAMWEn     <= wen_n;
      if (!op_wr && last && state == LOW)  readdata[15:0]  <= sample;
      if (!op_wr && last && state == HIGH) readdata[31:16] <= sample;
    end
  end

  sram_tristate u_bus (
    .clk       (clk),
    .rst       (rst),
    .drive_d   (drive_n),
    .data_d    (dout_n),
    .sample    (sample),
    .sram_data (SRAMdata)
  );

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Responder to the MEM-stage data-memory request port. It accepts one 32-bit word read or write per transaction and splits it into two 16-bit accesses on the external asynchronous SRAM (EP2C35 board SRAM). It holds `SRAM_NOT_READY` high, which freezes the pipeline (`superStall`), until the word is complete. It sits between the MEM stage (`read`, `write`, `aluResult`, `writedata`, `readdata`) and the board pins (`SRAMaddress`, `SRAMWEn`, `SRAMdata`).

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address of data-memory word 0; subtracted from `aluResult`.
- `WAIT_CYCLES`, default 2 (legal 1–15): clock cycles per 16-bit SRAM phase.

Ports:
- `clk`  in  1: single clock; all state is updated on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `read`  in  1: word-read request; held stable by the pipeline while stalled.
- `write`  in  1: word-write request; takes priority if `read` is also high.
- `aluResult`  in  32: byte address.
- `writedata`  in  32: store data.
- `readdata`  out  32: registered load data.
- `SRAM_NOT_READY`  out  1: combinational stall to the pipeline.
- `SRAMaddress`  out  18: SRAM half-word address.
- `SRAMWEn`  out  1: SRAM write enable, active-low.
- `SRAMdata`  inout  16: SRAM data bus; high-Z unless writing.

## Operation
- Address mapping:
  - `off = aluResult - BASE_ADDR`, computed mod 2^32.
  - `SRAMaddress = {off[18:2], half}`, where `half` is 0 for the low phase and 1 for the high phase.
  - `off[1:0]` is ignored.
  - Higher bits are discarded, so out-of-range addresses wrap silently.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if `read|write`, latch `off`, the operation (write wins) and `writedata`, then go to LOW with the wait counter at 0. Otherwise stay in IDLE.
  - LOW: counts `WAIT_CYCLES` cycles. `half`=0. On a write, drive `writedata[15:0]`.
  - HIGH: same as LOW, with `half`=1 and `writedata[31:16]` driven on a write.
  - DONE: lasts one cycle, then returns to IDLE. This cycle is the pipeline's advance cycle.
- Reads: `SRAMdata` is high-Z throughout. On the last cycle of LOW, capture `SRAMdata` into `readdata[15:0]`. On the last cycle of HIGH, capture it into `readdata[31:16]`.
- Writes:
  - `SRAMWEn`=0 for every cycle of LOW and HIGH except the final cycle of each phase, so the address and data are stable when `SRAMWEn` rises.
  - With `WAIT_CYCLES`=1, `SRAMWEn` is low for the entire phase.
  - Writes leave `readdata` unchanged.
- `SRAM_NOT_READY = (read|write) & (state != DONE)`.
  - In IDLE with no request it is 0.
- Requests that drop mid-transaction (flush): the transaction still completes to DONE. `SRAM_NOT_READY` follows its formula.
- Outputs in IDLE and DONE:
  - `SRAMaddress` holds its last value.
  - `SRAMWEn`=1.
  - `SRAMdata` is high-Z.

## Timing
- Reset values: state IDLE, counter 0, `readdata`=0, `SRAMaddress`=0, `SRAMWEn`=1, `SRAMdata` high-Z, `SRAM_NOT_READY`=`read|write`.
- Latency:
  - A request first seen in IDLE at cycle 0 reaches DONE at cycle `2*WAIT_CYCLES+1`.
  - `SRAM_NOT_READY` is high for `2*WAIT_CYCLES+1` cycles, 5 with the defaults.
  - The pipeline advances on the clock edge that ends DONE.
- Back-to-back requests: after DONE, the next request is accepted in the following IDLE cycle. There is one idle cycle between transactions, and no overlap.
- Reset asserted mid-transaction:
  - Immediately: `SRAMWEn`=1 and `SRAMdata` is released.
  - No partial-word completion is guaranteed.
- `SRAMWEn`, `SRAMaddress` and the bus drive enable are registered outputs, so there are no glitches on the pins.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - `SRAM_ADDR_W`=18 and `SRAM_DATA_W`=16;
  - the default `BASE_ADDR`.
- One sub-module: `sram_tristate`, containing the bus drive enable, output data register and input sample path. This keeps the inout isolated for FPGA I/O-cell packing.
- The wait counter and FSM stay in `sram_ctrl`.

## Test plan
- Write `aluResult`=1028, `writedata`=0xDEADBEEF, defaults:
  - SRAM half-word 2 = 0xBEEF, half-word 3 = 0xDEAD;
  - `SRAM_NOT_READY` high for exactly 5 cycles;
  - `SRAMWEn` low in cycles 1 and 3 only.
- Read back 1028 with a behavioural SRAM model: in the DONE cycle `readdata`=0xDEADBEEF, `SRAM_NOT_READY`=0, and the bus is never driven by the DUT.
- `read` and `write` high together, address 1032, data 0x12345678: treated as a write, memory updated, `readdata` unchanged from its previous value.
- `WAIT_CYCLES`=1, two back-to-back reads of 1024 and 1028: each stalls 3 cycles, with a single IDLE cycle between them, and correct data is returned.
- Assert `rst` in the middle of the HIGH phase of a write: in the same cycle `SRAMWEn`=1 and `SRAMdata` is high-Z; after release the FSM is IDLE and `readdata`=0.
- `aluResult`=1024+2^19 wraps to `SRAMaddress` 0/1; `aluResult`=1026 maps to the same word as 1024.
